// File: rtl/pld_rr_sched_pkg.sv
// Purpose: shared types and gate function for the round-robin PLD scheduler.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package pld_rr_sched_pkg;

    // Operand bundle as presented by a requester: bit5=a .. bit0=f.
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
    } pld_in_t;

    // Result bundle: bit4=v .. bit0=z.
    typedef struct packed {
        logic v;
        logic w;
        logic x;
        logic y;
        logic z;
    } pld_out_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    // The shared combinational gate function.
    function automatic pld_out_t pld_eval(input pld_in_t in);
        pld_out_t out;
        out.v = in.a & in.b;
        out.w = in.a | in.b | in.c;
        out.x = ~(in.c & in.d & in.e & in.f);
        out.y = ~(in.a | in.b | in.c);
        out.z = ~in.a;
        return out;
    endfunction

endpackage

// File: rtl/pld_rr_arbiter.sv
// Purpose: round-robin pick of the first active request at or above the pointer, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the grant with its own state.
module pld_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    int             pos;
    logic [IDW-1:0] cand;

    // Walk the requesters starting at the pointer; first active one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            cand = IDW'(pos);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/pld_rr_sched.sv
// Purpose: round-robin share of one PLD gate evaluation among N_REQ requesters (PLD_RR_SCHED_STATS_EN adds grant counters).
// Latency: accept in cycle T gives resp_valid in T+2; at least 3 cycles per operation.
// Backpressure: one op in flight; req_ready held low until the response handshake completes.
module pld_rr_sched
    import pld_rr_sched_pkg::*;
#(
    parameter int N_REQ = 4
`ifdef PLD_RR_SCHED_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0][5:0]      req_data,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic [4:0]                 resp_data,
    output logic                       busy
`ifdef PLD_RR_SCHED_STATS_EN
    ,
    output logic [N_REQ-1:0][CNT_W-1:0] grant_cnt
`endif
);

    localparam int IDW = $clog2(N_REQ);

    state_t         state;
    logic [IDW-1:0] ptr;
    pld_in_t        op;
    logic [N_REQ-1:0] win_grant;
    logic [IDW-1:0] win_idx;
    logic           win_any;
    logic           accept;

    pld_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign accept = (state == IDLE) && win_any;

    // Ready only goes to the arbitration winner, and only while idle.
    always_comb begin
        req_ready = '0;
        if (state == IDLE) req_ready = win_grant;
    end

    // Control FSM with operand, result, id and pointer registers; outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            op         <= '0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op      <= pld_in_t'(req_data[win_idx]);
                        resp_id <= win_idx;
                        ptr     <= (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + IDW'(1);
                        busy    <= 1'b1;
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    resp_data  <= pld_eval(op);
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef PLD_RR_SCHED_STATS_EN
    // Per-requester accept counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (accept && (grant_cnt[win_idx] != {CNT_W{1'b1}})) begin
            grant_cnt[win_idx] <= grant_cnt[win_idx] + CNT_W'(1);
        end
    end
`endif

endmodule
